// File: rtl/mux_4_1_rr_arbiter_pkg.sv
// Shared constants and types for the four-way round-robin select path.
// Requester indices are used for the priority pointer and the output source tag.
package mux_arb_pkg;

  localparam int N_SRC = 4;
  localparam int SRC_W = 2;

  typedef logic [SRC_W-1:0] src_idx_t;

  // Index of the requester that follows idx, wrapping 3 -> 0.
  function automatic src_idx_t next_idx(input src_idx_t idx);
    return src_idx_t'(idx + src_idx_t'(1));
  endfunction

endpackage

// File: rtl/mux_4_1_rr_arbiter_if.sv
// Bundles the four requester channels and the single output channel.
// slave is the arbiter's view, master is the producer/consumer side.
interface mux_4_1_rr_arbiter_if
  import mux_arb_pkg::*;
#(
  parameter int WIDTH = 4
);

  logic [N_SRC-1:0] in_valid;
  logic [WIDTH-1:0] in_data0;
  logic [WIDTH-1:0] in_data1;
  logic [WIDTH-1:0] in_data2;
  logic [WIDTH-1:0] in_data3;
  logic [N_SRC-1:0] in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  src_idx_t         out_src;
  logic             out_ready;

  modport slave (
    input  in_valid, in_data0, in_data1, in_data2, in_data3, out_ready,
    output in_ready, out_valid, out_data, out_src
  );

  modport master (
    output in_valid, in_data0, in_data1, in_data2, in_data3, out_ready,
    input  in_ready, out_valid, out_data, out_src
  );

endinterface

// File: rtl/mux_4_1_rr_arbiter_rr_pick_4.sv
// Combinational rotating-priority picker: first asserted request at or after ptr.
module rr_pick_4
  import mux_arb_pkg::*;
(
  input  logic [N_SRC-1:0] req,
  input  src_idx_t         ptr,
  output logic [N_SRC-1:0] gnt,
  output src_idx_t         gnt_idx,
  output logic             any
);

  src_idx_t idx;

  // Scan from the farthest offset down so the offset closest to ptr wins.
  always_comb begin
    gnt_idx = ptr;
    any     = 1'b0;
    idx     = ptr;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      idx = src_idx_t'(ptr + src_idx_t'(k));
      if (req[idx]) begin
        gnt_idx = idx;
        any     = 1'b1;
      end
    end
  end

  always_comb begin
    gnt          = '0;
    gnt[gnt_idx] = any;
  end

endmodule

// File: rtl/mux_4_1_rr_arbiter.sv
// Round-robin arbitration of four valid/ready requesters onto one registered
// output word with its own valid/ready handshake; one word per clock sustained.
module mux_4_1_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mux_4_1_rr_arbiter_if.slave  bus
);

  src_idx_t         ptr;
  logic [N_SRC-1:0] gnt;
  src_idx_t         gnt_idx;
  logic             any;
  logic             load;
  logic             xfer;
  logic [WIDTH-1:0] sel_data_p0;

  logic             vld_p1;
  logic [WIDTH-1:0] data_p1;
  src_idx_t         src_p1;

  rr_pick_4 u_pick (
    .req     (bus.in_valid),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any)
  );

  // Register accepts a word when empty or being drained this cycle.
  assign load = ~vld_p1 | bus.out_ready;
  assign xfer = load & any;

  assign bus.in_ready = (rst_n && load) ? gnt : '0;

  always_comb begin
    sel_data_p0 = bus.in_data0;
    case (gnt_idx)
      2'd0:    sel_data_p0 = bus.in_data0;
      2'd1:    sel_data_p0 = bus.in_data1;
      2'd2:    sel_data_p0 = bus.in_data2;
      default: sel_data_p0 = bus.in_data3;
    endcase
  end

  // ---- p0 -> p1: output register and priority pointer ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      src_p1  <= '0;
      ptr     <= '0;
    end else if (xfer) begin
      vld_p1  <= 1'b1;
      data_p1 <= sel_data_p0;
      src_p1  <= gnt_idx;
      ptr     <= next_idx(gnt_idx);
    end else if (bus.out_ready) begin
      vld_p1  <= 1'b0;
    end
  end

  assign bus.out_valid = vld_p1;
  assign bus.out_data  = data_p1;
  assign bus.out_src   = src_p1;

endmodule

// File: tb/tb_mux_4_1_rr_arbiter.sv
// Directed bench for mux_4_1_rr_arbiter with hand-computed expectations.
module tb_mux_4_1_rr_arbiter;
  import mux_arb_pkg::*;

  localparam int WIDTH = 4;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  mux_4_1_rr_arbiter_if #(.WIDTH(WIDTH)) bus ();

  mux_4_1_rr_arbiter #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.in_valid = 4'h0;
    bus.out_ready = 1'b1;
    #3;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 4'hF;
    bus.in_data0 = 4'ha; bus.in_data1 = 4'hb; bus.in_data2 = 4'hc; bus.in_data3 = 4'hd;
    bus.out_ready = 1'b1;
    #3;
    @(negedge clk);
    vectors++; if (bus.in_ready !== 4'b0000) begin miscompares++; $display("FAIL rst_in_ready got=%b exp=0000", bus.in_ready); end
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid); end
    vectors++; if (bus.out_data !== 4'h0) begin miscompares++; $display("FAIL rst_out_data got=%h exp=0", bus.out_data); end
    vectors++; if (bus.out_src !== 2'd0) begin miscompares++; $display("FAIL rst_out_src got=%0d exp=0", bus.out_src); end
    rst_n = 1'b1;
    bus.in_valid = 4'b0001;
    #1;
    vectors++; if (bus.in_ready !== 4'b0001) begin miscompares++; $display("FAIL first_in_ready got=%b exp=0001", bus.in_ready); end
    step();
    vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL first_out_valid got=%b exp=1", bus.out_valid); end
    vectors++; if (bus.out_data !== 4'ha) begin miscompares++; $display("FAIL first_out_data got=%h exp=a", bus.out_data); end
    vectors++; if (bus.out_src !== 2'd0) begin miscompares++; $display("FAIL first_out_src got=%0d exp=0", bus.out_src); end
  endtask

  task automatic test_round_robin();
    logic [WIDTH-1:0] exp_d [5];
    logic [1:0]       exp_s [5];
    exp_d = '{4'ha, 4'hb, 4'hc, 4'hd, 4'ha};
    exp_s = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    do_reset();
    bus.in_valid = 4'hF;
    bus.out_ready = 1'b1;
    #1;
    vectors++; if (bus.in_ready !== 4'b0001) begin miscompares++; $display("FAIL rr_in_ready0 got=%b exp=0001", bus.in_ready); end
    for (int i = 0; i < 5; i++) begin
      step();
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== exp_d[i] || bus.out_src !== exp_s[i]) begin
        miscompares++;
        $display("FAIL rr_cycle%0d got v=%b d=%h s=%0d exp v=1 d=%h s=%0d", i, bus.out_valid, bus.out_data, bus.out_src, exp_d[i], exp_s[i]);
      end
    end
  endtask

  task automatic test_skip_idle();
    // Pointer is 1 after the final grant to requester 0.
    bus.in_valid = 4'b1001;
    #1;
    vectors++; if (bus.in_ready !== 4'b1000) begin miscompares++; $display("FAIL skip_in_ready got=%b exp=1000", bus.in_ready); end
    step();
    vectors++; if (bus.out_src !== 2'd3 || bus.out_data !== 4'hd) begin miscompares++; $display("FAIL skip_grant3 got s=%0d d=%h exp s=3 d=d", bus.out_src, bus.out_data); end
    vectors++; if (bus.in_ready !== 4'b0001) begin miscompares++; $display("FAIL wrap_in_ready got=%b exp=0001", bus.in_ready); end
    step();
    vectors++; if (bus.out_src !== 2'd0 || bus.out_data !== 4'ha) begin miscompares++; $display("FAIL wrap_grant0 got s=%0d d=%h exp s=0 d=a", bus.out_src, bus.out_data); end
  endtask

  task automatic test_single();
    bus.in_valid = 4'b0010;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++; if (bus.in_ready !== 4'b0010) begin miscompares++; $display("FAIL single_in_ready%0d got=%b exp=0010", i, bus.in_ready); end
      step();
      vectors++; if (bus.out_valid !== 1'b1 || bus.out_src !== 2'd1 || bus.out_data !== 4'hb) begin miscompares++; $display("FAIL single_out%0d got v=%b s=%0d d=%h exp v=1 s=1 d=b", i, bus.out_valid, bus.out_src, bus.out_data); end
    end
  endtask

  task automatic test_backpressure();
    bus.in_valid = 4'b0100;
    bus.out_ready = 1'b1;
    step();
    vectors++; if (bus.out_src !== 2'd2 || bus.out_data !== 4'hc) begin miscompares++; $display("FAIL bp_fill got s=%0d d=%h exp s=2 d=c", bus.out_src, bus.out_data); end
    bus.out_ready = 1'b0;
    bus.in_valid = 4'hF;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++; if (bus.in_ready !== 4'b0000) begin miscompares++; $display("FAIL bp_in_ready%0d got=%b exp=0000", i, bus.in_ready); end
      step();
      vectors++; if (bus.out_valid !== 1'b1 || bus.out_data !== 4'hc || bus.out_src !== 2'd2) begin miscompares++; $display("FAIL bp_hold%0d got v=%b d=%h s=%0d exp v=1 d=c s=2", i, bus.out_valid, bus.out_data, bus.out_src); end
    end
    bus.out_ready = 1'b1;
    #1;
    vectors++; if (bus.in_ready !== 4'b1000) begin miscompares++; $display("FAIL bp_release_ready got=%b exp=1000", bus.in_ready); end
    step();
    vectors++; if (bus.out_data !== 4'hd || bus.out_src !== 2'd3) begin miscompares++; $display("FAIL bp_release_out got d=%h s=%0d exp d=d s=3", bus.out_data, bus.out_src); end
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b1;
    bus.in_valid = 4'b0100;
    bus.in_data2 = 4'h7;
    step();
    vectors++; if (bus.out_valid !== 1'b1 || bus.out_data !== 4'h7) begin miscompares++; $display("FAIL drain_load got v=%b d=%h exp v=1 d=7", bus.out_valid, bus.out_data); end
    bus.in_valid = 4'b0000;
    step();
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL drain_empty got v=%b exp v=0", bus.out_valid); end
    vectors++; if (bus.out_data !== 4'h7) begin miscompares++; $display("FAIL drain_data_hold got d=%h exp d=7", bus.out_data); end
    step();
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL idle_stays_empty got v=%b exp v=0", bus.out_valid); end
  endtask

  task automatic test_async_reset();
    bus.in_data2 = 4'hc;
    bus.in_valid = 4'b0010;
    bus.out_ready = 1'b0;
    step();
    vectors++; if (bus.out_valid !== 1'b1 || bus.out_src !== 2'd1) begin miscompares++; $display("FAIL ar_preload got v=%b s=%0d exp v=1 s=1", bus.out_valid, bus.out_src); end
    bus.in_valid = 4'hF;
    #2;
    rst_n = 1'b0;
    #1;
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL ar_out_valid got=%b exp=0", bus.out_valid); end
    vectors++; if (bus.out_data !== 4'h0 || bus.out_src !== 2'd0) begin miscompares++; $display("FAIL ar_out_regs got d=%h s=%0d exp d=0 s=0", bus.out_data, bus.out_src); end
    vectors++; if (bus.in_ready !== 4'b0000) begin miscompares++; $display("FAIL ar_in_ready got=%b exp=0000", bus.in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    vectors++; if (bus.in_ready !== 4'b0001) begin miscompares++; $display("FAIL ar_post_ready got=%b exp=0001", bus.in_ready); end
    step();
    vectors++; if (bus.out_valid !== 1'b1 || bus.out_src !== 2'd0 || bus.out_data !== 4'ha) begin miscompares++; $display("FAIL ar_post_grant got v=%b s=%0d d=%h exp v=1 s=0 d=a", bus.out_valid, bus.out_src, bus.out_data); end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    bus.in_valid = 4'h0;
    bus.in_data0 = 4'h0; bus.in_data1 = 4'h0; bus.in_data2 = 4'h0; bus.in_data3 = 4'h0;
    bus.out_ready = 1'b0;
    test_reset();
    test_round_robin();
    test_skip_idle();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
